// File: rtl/caches_pkg.sv
// Shared types for the cache-side memory arbiter: FSM states and the latched request.
package caches_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    D_ACC,
    I_ACC,
    D_RESP,
    I_RESP
  } arb_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } arb_op_t;

  typedef struct packed {
    arb_op_t op;
    word_t   addr;
    word_t   wdata;
  } arb_req_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Serialises icache/dcache word requests onto one single-port RAM, with a
// starvation limit on back-to-back dcache grants while the icache waits.
module cache_mem_arbiter
  import caches_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              load_done,
  output logic              store_done,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  arb_state_t       state, next_state;
  arb_req_t         req_q;
  word_t            rdata_q;
  logic [CNT_W-1:0] starve_cnt;
  logic             dropped_q;

  logic d_req, grant_d, grant_i, d_ok, i_ok, in_acc;

  // Control state is reset; the latched request and read data are qualified by state.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      dropped_q  <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE) begin
        if (!iREN || grant_i)
          starve_cnt <= '0;
        else if (grant_d && starve_cnt != CNT_W'(STARVE_MAX))
          starve_cnt <= starve_cnt + CNT_W'(1);
      end
      // A requester that lets go at any point during the access loses its response.
      if (grant_d || grant_i)
        dropped_q <= 1'b0;
      else if ((state == D_ACC && !d_req) || (state == I_ACC && !iREN))
        dropped_q <= 1'b1;
      if (grant_d) begin
        req_q.op    <= dWEN ? OP_WRITE : OP_READ;
        req_q.addr  <= daddr;
        req_q.wdata <= dstore;
      end else if (grant_i) begin
        req_q.op    <= OP_READ;
        req_q.addr  <= iaddr;
        req_q.wdata <= '0;
      end
      if (in_acc && ram_ready)
        rdata_q <= ram_rdata;
    end
  end

  always_comb begin
    next_state = state;
    ram_ren    = 1'b0;
    ram_wen    = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    dload      = '0;
    iload      = '0;
    load_done  = 1'b0;
    store_done = 1'b0;

    d_req   = dREN | dWEN;
    grant_d = (state == IDLE) && d_req &&
              !(iREN && starve_cnt == CNT_W'(STARVE_MAX));
    grant_i = (state == IDLE) && iREN && !grant_d;
    in_acc  = (state == D_ACC) || (state == I_ACC);
    d_ok    = (state == D_RESP) && d_req && !dropped_q;
    i_ok    = (state == I_RESP) && iREN && !dropped_q;

    case (state)
      IDLE: begin
        if (grant_d)
          next_state = D_ACC;
        else if (grant_i)
          next_state = I_ACC;
      end
      D_ACC, I_ACC: begin
        ram_ren   = (req_q.op == OP_READ);
        ram_wen   = (req_q.op == OP_WRITE);
        ram_addr  = req_q.addr;
        ram_wdata = req_q.wdata;
        if (ram_ready)
          next_state = (state == D_ACC) ? D_RESP : I_RESP;
      end
      D_RESP: begin
        next_state = IDLE;
        if (d_ok) begin
          load_done  = (req_q.op == OP_READ);
          store_done = (req_q.op == OP_WRITE);
          if (req_q.op == OP_READ)
            dload = rdata_q;
        end
      end
      I_RESP: begin
        next_state = IDLE;
        if (i_ok)
          iload = rdata_q;
      end
      default: next_state = IDLE;
    endcase

    dwait = d_req && !d_ok;
    iwait = iREN && !i_ok;
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomised bench for cache_mem_arbiter: a transaction-level model predicts grant
// order, RAM accesses and returned data; a behavioural RAM answers with set latency.
module tb_cache_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          dREN, dWEN, iREN;
  logic [AW-1:0] daddr, iaddr, ram_addr;
  logic [DW-1:0] dstore, dload, iload, ram_wdata, ram_rdata;
  logic          dwait, iwait, load_done, store_done;
  logic          ram_ren, ram_wen, ram_ready;

  always #5 CLK = ~CLK;

  cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .nRST(nRST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload), .load_done(load_done), .store_done(store_done),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Behavioural RAM: ready pulses lat cycles after the strobe first appears.
  logic [31:0] ram_mem [1024];
  bit          ram_vld [1024];
  int          lat = 1;
  int          lat_cnt;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ram_ready <= 1'b0;
      lat_cnt   <= 0;
      ram_rdata <= '0;
    end else begin
      ram_ready <= 1'b0;
      if ((ram_ren || ram_wen) && !ram_ready) begin
        if (lat_cnt + 1 >= lat) begin
          ram_ready <= 1'b1;
          lat_cnt   <= 0;
          ram_rdata <= ram_vld[ram_addr[11:2]] ? ram_mem[ram_addr[11:2]] : init_word(ram_addr);
          if (ram_wen) begin
            ram_mem[ram_addr[11:2]] <= ram_wdata;
            ram_vld[ram_addr[11:2]] <= 1'b1;
          end
        end else begin
          lat_cnt <= lat_cnt + 1;
        end
      end
    end
  end

  typedef struct { int op; logic [31:0] addr; logic [31:0] wdata; } txn_t;  // op 0 rd, 1 wr, 2 both
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } acc_t;

  logic [31:0] ref_mem [1024];
  txn_t        dq[$], iq[$];
  acc_t        exp_acc[$];
  bit          exp_dw[$];
  logic [31:0] exp_d[$], exp_i[$];
  int          d_done_k[$];
  bit          d_act, i_act;
  txn_t        dcur, icur;

  function automatic txn_t mk(input int op, input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.op = op; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  // Serialised schedule from the grant rule and a starvation counter.
  task automatic predict();
    int di, ii, cnt;
    bit dp, ip, gd;
    txn_t t;
    acc_t a;
    di = 0; ii = 0; cnt = 0;
    while (di < dq.size() || ii < iq.size()) begin
      dp = di < dq.size();
      ip = ii < iq.size();
      gd = dp && !(ip && cnt == SMAX);
      if (!ip || !gd) cnt = 0;
      else if (cnt < SMAX) cnt++;
      if (gd) begin
        t = dq[di]; di++;
        a.we = (t.op != 0); a.addr = t.addr; a.wdata = t.wdata;
        exp_acc.push_back(a);
        exp_dw.push_back(a.we);
        if (a.we) ref_mem[t.addr[11:2]] = t.wdata;
        else exp_d.push_back(ref_mem[t.addr[11:2]]);
      end else begin
        t = iq[ii]; ii++;
        a.we = 1'b0; a.addr = t.addr; a.wdata = '0;
        exp_acc.push_back(a);
        exp_i.push_back(ref_mem[t.addr[11:2]]);
      end
    end
  endtask

  task automatic present();
    if (!d_act && dq.size() > 0) begin dcur = dq.pop_front(); d_act = 1'b1; end
    if (!i_act && iq.size() > 0) begin icur = iq.pop_front(); i_act = 1'b1; end
    dREN   = d_act && dcur.op != 1;
    dWEN   = d_act && dcur.op != 0;
    daddr  = d_act ? dcur.addr : '0;
    dstore = d_act ? dcur.wdata : '0;
    iREN   = i_act;
    iaddr  = i_act ? icur.addr : '0;
  endtask

  task automatic run_batch(input int l, output int first_k, output string order);
    int   k;
    bit   dd, we;
    acc_t a;
    predict();
    lat = l; first_k = -1; order = ""; d_done_k.delete();
    @(negedge CLK);
    present();
    k = 0;
    while ((d_act || i_act) && k < 400) begin
      @(negedge CLK);
      k++;
      if (ram_ready && (ram_ren || ram_wen)) begin
        if (exp_acc.size() == 0) check_eq("acc_extra", 32'(ram_addr), 32'hFFFFFFFF);
        else begin
          a = exp_acc.pop_front();
          check_eq("acc_we", 32'(ram_wen), 32'(a.we));
          check_eq("acc_addr", ram_addr, a.addr);
          if (a.we) check_eq("acc_wdata", ram_wdata, a.wdata);
        end
      end
      dd = load_done || store_done;
      if (d_act) begin
        check_eq("dwait", 32'(dwait), 32'(!dd));
        if (dd) begin
          if (exp_dw.size() == 0) check_eq("d_extra", 32'(dd), 32'(0));
          else begin
            we = exp_dw.pop_front();
            check_eq("store_done", 32'(store_done), 32'(we));
            check_eq("load_done", 32'(load_done), 32'(!we));
            if (!we && exp_d.size() > 0) check_eq("dload", dload, exp_d.pop_front());
          end
          d_act = 1'b0;
          order = {order, "D"};
          d_done_k.push_back(k);
          if (first_k < 0) first_k = k;
        end
      end else begin
        check_eq("d_spurious", 32'(dd), 32'(0));
      end
      if (i_act && !iwait) begin
        if (exp_i.size() == 0) check_eq("i_extra", iload, 32'hFFFFFFFF);
        else check_eq("iload", iload, exp_i.pop_front());
        i_act = 1'b0;
        order = {order, "I"};
        if (first_k < 0) first_k = k;
      end
      present();
    end
    check_eq("batch_timeout", 32'(k < 400), 32'(1));
    check_eq("acc_left", 32'(exp_acc.size()), 32'(0));
  endtask

  initial begin
    int    fk, k, nd, ni;
    bit    seen;
    string ord, exp3;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(32'(i) << 2);
    nRST = 1'b0; dREN = 1'b0; dWEN = 1'b0; iREN = 1'b0;
    daddr = '0; dstore = '0; iaddr = '0;
    d_act = 1'b0; i_act = 1'b0;
    repeat (2) @(negedge CLK);
    check_eq("rst_ren", 32'(ram_ren), 32'(0));
    check_eq("rst_wen", 32'(ram_wen), 32'(0));
    check_eq("rst_addr", ram_addr, 32'h0);
    check_eq("rst_done", 32'({load_done, store_done}), 32'(0));
    check_eq("rst_dload", dload, 32'h0);
    check_eq("rst_iload", iload, 32'h0);
    check_eq("rst_waits", 32'({dwait, iwait}), 32'(0));
    dREN = 1'b1;
    #1 check_eq("rst_dwait_req", 32'(dwait), 32'(1));
    dREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;

    // Test 1: single dcache read, ready one cycle after the strobe
    dq.push_back(mk(0, 32'h100, 32'h0));
    run_batch(1, fk, ord);
    check_eq("t1_latency", 32'(fk), 32'(3));

    // Test 2: two-word writeback with an idle cycle between
    dq.push_back(mk(1, 32'h200, 32'h11));
    dq.push_back(mk(1, 32'h204, 32'h22));
    run_batch(1, fk, ord);
    check_eq("t2_count", 32'(d_done_k.size()), 32'(2));
    if (d_done_k.size() == 2) check_eq("t2_gap", 32'(d_done_k[1] - d_done_k[0]), 32'(4));

    // Test 3: both requesters held; icache gets in after STARVE_MAX dcache grants
    for (int j = 0; j < 5; j++) dq.push_back(mk(0, 32'h600 + 32'(j * 4), 32'h0));
    iq.push_back(mk(0, 32'h700, 32'h0));
    run_batch(1, fk, ord);
    exp3 = "DDDDID";
    check_eq("t3_len", 32'(ord.len()), 32'(6));
    for (int j = 0; j < 6 && j < ord.len(); j++) check_eq("t3_order", 32'(ord.getc(j)), 32'(exp3.getc(j)));

    // Test 4: dREN dropped during a slow read; address change is ignored
    lat = 5;
    @(negedge CLK);
    dREN = 1'b1; daddr = 32'h400;
    k = 0;
    while (!ram_ren && k < 10) begin @(negedge CLK); k++; end
    check_eq("t4_acc", 32'(ram_ren), 32'(1));
    dREN = 1'b0; daddr = 32'h7FC;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      check_eq("t4_no_ld", 32'(load_done), 32'(0));
      check_eq("t4_dwait", 32'(dwait), 32'(0));
      if (!seen) begin
        check_eq("t4_hold", 32'(ram_ren), 32'(1));
        check_eq("t4_addr", ram_addr, 32'h400);
      end
      if (ram_ready) seen = 1'b1;
    end
    check_eq("t4_ram_done", 32'(seen), 32'(1));
    daddr = '0;
    iq.push_back(mk(0, 32'h404, 32'h0));
    run_batch(1, fk, ord);
    check_eq("t4_i_latency", 32'(fk), 32'(3));

    // Test 5: asynchronous reset in D_ACC
    lat = 3;
    @(negedge CLK);
    dREN = 1'b1; daddr = 32'h500;
    k = 0;
    while (!ram_ren && k < 10) begin @(negedge CLK); k++; end
    check_eq("t5_acc", 32'(ram_ren), 32'(1));
    #2 nRST = 1'b0;
    #1;
    check_eq("t5_ren", 32'(ram_ren), 32'(0));
    check_eq("t5_wen", 32'(ram_wen), 32'(0));
    check_eq("t5_addr", ram_addr, 32'h0);
    check_eq("t5_done", 32'({load_done, store_done}), 32'(0));
    check_eq("t5_dload", dload, 32'h0);
    check_eq("t5_dwait", 32'(dwait), 32'(1));
    @(negedge CLK);
    dREN = 1'b0; daddr = '0;
    nRST = 1'b1;
    #1 check_eq("t5_dwait_idle", 32'(dwait), 32'(0));
    dq.push_back(mk(0, 32'h500, 32'h0));
    run_batch(2, fk, ord);
    check_eq("t5_latency", 32'(fk), 32'(4));

    // Test 6: dREN and dWEN together behave as a write, then read back
    dq.push_back(mk(2, 32'h300, 32'hCAFEF00D));
    dq.push_back(mk(0, 32'h300, 32'h0));
    run_batch(1, fk, ord);

    // Random mixes of reads, writes and icache fetches
    for (int b = 0; b < 25; b++) begin
      nd = $urandom_range(0, 4);
      ni = $urandom_range(0, 4);
      if (nd + ni == 0) nd = 1;
      for (int j = 0; j < nd; j++)
        dq.push_back(mk($urandom_range(0, 2), {20'h0, 10'($urandom_range(0, 1023)), 2'b00}, $urandom()));
      for (int j = 0; j < ni; j++)
        iq.push_back(mk(0, {20'h0, 10'($urandom_range(0, 1023)), 2'b00}, 32'h0));
      run_batch($urandom_range(1, 4), fk, ord);
      check_eq("rnd_count", 32'(ord.len()), 32'(nd + ni));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
